// File: rtl/scr_word_tx_if.sv
// Upstream word stream of the scrambler transmit block: words in with
// valid/ready, and the core's results returned with a one-cycle valid pulse.
interface scr_word_tx_if;
    logic [5:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] res_data;
    logic       res_valid;

    // Upstream source / result consumer
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  res_data,
        input  res_valid
    );

    // Transmit block
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output res_data,
        output res_valid
    );
endinterface

// File: rtl/scr_word_tx.sv
// Transmit side of the 6-bit strobed word interface. Words are buffered in a
// small FIFO, presented on x_tx, committed with a one-cycle low pulse on stbo,
// and the core result is sampled a fixed gap later and returned upstream.
module scr_word_tx #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned HOLD_CYC = 2,
    parameter int unsigned GAP_CYC  = 24
) (
    input  logic                   clock,
    input  logic                   reset,
    scr_word_tx_if.slave           up,
    output logic [5:0]             x_tx,
    output logic                   stbo,
    input  logic [5:0]             res_in,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned LvlW   = PtrW + 1;
    localparam int unsigned MaxCnt = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int unsigned CntW   = $clog2(MaxCnt) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StCommit,
        StWait
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LvlW-1:0]   level_q, level_d;
    logic              in_ready_q, in_ready_d;
    logic [5:0]        x_q, x_d;
    logic              stbo_q, stbo_d;
    logic [5:0]        res_data_q, res_data_d;
    logic              res_valid_q, res_valid_d;
    logic [5:0]        mem_q [DEPTH];

    logic              push;
    logic              pop;

    // in_ready comes from a register, so push never depends combinationally on it
    assign push = up.in_valid & in_ready_q;

    // Word sequencer: pop, hold, commit, wait for the core, then sample the result
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        res_data_d  = res_data_q;
        res_valid_d = 1'b0;
        pop         = 1'b0;

        case (state_q)
            StIdle: begin
                if (level_q != '0) begin
                    pop     = 1'b1;
                    x_d     = mem_q[rd_ptr_q];
                    cnt_d   = CntW'(HOLD_CYC - 1);
                    state_d = StHold;
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    state_d = StCommit;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StCommit: begin
                cnt_d   = CntW'(GAP_CYC - 1);
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q == '0) begin
                    res_data_d  = res_in;
                    res_valid_d = 1'b1;
                    state_d     = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // stbo is registered: it goes low exactly for the cycle spent in COMMIT
        stbo_d = (state_d != StCommit);
    end

    // FIFO pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase

        in_ready_d = (level_d < LvlW'(DEPTH));
    end

    // Control and output registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            level_q     <= '0;
            in_ready_q  <= 1'b1;
            x_q         <= '0;
            stbo_q      <= 1'b1;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            level_q     <= level_d;
            in_ready_q  <= in_ready_d;
            x_q         <= x_d;
            stbo_q      <= stbo_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers gate every read
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= up.in_data;
        end
    end

    assign up.in_ready  = in_ready_q;
    assign up.res_data  = res_data_q;
    assign up.res_valid = res_valid_q;
    assign x_tx         = x_q;
    assign stbo         = stbo_q;
    assign fifo_level   = level_q;

endmodule

// File: doc/scr_word_tx.md
Name: scr_word_tx

Overview:
- Transmit side of the 6-bit strobed word interface consumed by the b11-style scrambler core.
- Accepts words from an upstream valid/ready source and buffers them in a small FIFO.
- Presents each word on x_tx and commits it with a one-cycle low pulse on stbo, while holding stbo high at all other times.
- Enforces a fixed processing gap per word, then samples the core's 6-bit result and returns it upstream with a one-cycle valid pulse.

Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- HOLD_CYC, 2: cycles x_tx is stable with stbo=1 before the commit pulse; minimum 1.
- GAP_CYC, 24: cycles after the commit pulse before res_in is sampled; minimum 1. Must cover worst-case core latency.

Ports:
- clock, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-low reset; sampled on the rising edge of clock.
- in_data, input, 6: word to transmit.
- in_valid, input, 1: in_data valid.
- in_ready, output, 1: FIFO can accept a word; equals (level < DEPTH) from registered state.
- x_tx, output, 6: word presented to the core's x_in.
- stbo, output, 1: to the core's stbi; 1 = hold/idle, 0 = commit.
- res_in, input, 6: core result (x_out).
- res_data, output, 6: captured result.
- res_valid, output, 1: one-cycle pulse when res_data updates.
- fifo_level, output, clog2(DEPTH)+1: current FIFO occupancy.

Behaviour:
- Reset (reset==0 at a clock edge):
  - FIFO empty; fifo_level=0; in_ready=1 from the next cycle.
  - x_tx=0, stbo=1, res_data=0, res_valid=0, state IDLE.
  - Reset mid-operation discards the in-flight word and all buffered words; stbo returns to 1 immediately after the edge.
- Push occurs when in_valid && in_ready. A push while full cannot happen (in_ready=0). There is no same-cycle bypass.
- Simultaneous push and pop: both take effect; level is unchanged.
- Pointers wrap modulo DEPTH.
- FSM states: IDLE, HOLD, COMMIT, WAIT.
  - IDLE: stbo=1, x_tx holds its last value.
    - If level>0 at the edge: pop head into x_tx, hold counter = HOLD_CYC-1, go to HOLD.
    - Otherwise stay in IDLE.
  - HOLD: stbo=1, x_tx stable.
    - At counter 0, go to COMMIT; otherwise decrement.
  - COMMIT: stbo=0 for exactly one cycle, x_tx stable.
    - Wait counter = GAP_CYC-1; go to WAIT.
  - WAIT: stbo=1, x_tx stable.
    - At counter 0: res_data<=res_in, res_valid<=1 for the next cycle only, go to IDLE. Otherwise decrement.
- Timing: a push at edge N into an empty FIFO with FSM in IDLE gives:
  - x_tx updated at edge N+1;
  - stbo=0 between edges N+1+HOLD_CYC and N+2+HOLD_CYC;
  - res_valid=1 for the cycle after edge N+2+HOLD_CYC+GAP_CYC.
- Back-to-back words: the next pop occurs in the IDLE cycle following WAIT. Word period = HOLD_CYC+GAP_CYC+2 cycles.
- stbo is never low for two consecutive cycles. x_tx never changes while stbo=0 or during WAIT.
- res_valid is never asserted except the cycle after WAIT exit. There is no backpressure on the result path; the consumer must accept it.
- All outputs are registered; no combinational path from in_valid to in_ready, or from res_in to res_data.

Test Plan:
- Reset then idle 10 cycles -> stbo=1, x_tx=0, res_valid=0, in_ready=1, fifo_level=0 throughout.
- Push 6'd13 at edge 0 (HOLD_CYC=2, GAP_CYC=24) -> x_tx=13 from edge 1; stbo=0 only between edges 3 and 4; res_valid=1 after edge 28 with res_data equal to res_in at edge 28.
- Push 5 words back-to-back (DEPTH=4) while the first is in flight -> in_ready drops at fifo_level=4, the 5th is held off until the first pop; words are sent in order with period 28 cycles; exactly 5 res_valid pulses.
- Push while full with a pop in the same cycle -> word accepted next cycle only; level never exceeds DEPTH; no word is lost or duplicated.
- Assert reset=0 for one edge during WAIT -> res_valid is not pulsed, stbo=1, FIFO empty, x_tx=0; a later push restarts normally.
- Words 6'd0 and 6'd63 -> transmitted unchanged on x_tx, with the same single-cycle stbo commit.
